video_timing_gen: RTL and testbench

- Display-side counterpart of the game graphics blocks: generates the pixel scan coordinates (pix_x, pix_y) they consume and accepts back their graph_on/graph_rgb.
- Produces 640x480@60 raster timing (800x525 total) plus a registered, blank-masked 3-bit RGB stream with hsync, vsync and data-enable aligned to it.
- Drives the HDMI/VGA encoder.

---
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_timing_gen.sv | 117 +++++++++++
 tb/tb_video_timing_gen.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster coordinate / pixel stream bundle between the timing
// generator (master) and the graphics layer plus display encoder (slave).
interface video_timing_gen_if;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       line_tick;
  logic       frame_tick;
  logic       graph_on;
  logic [2:0] graph_rgb;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [2:0] rgb;

  modport master (
    output pix_x, pix_y, video_on, line_tick, frame_tick,
    output hsync, vsync, de, rgb,
    input  graph_on, graph_rgb
  );

  modport slave (
    input  pix_x, pix_y, video_on, line_tick, frame_tick,
    input  hsync, vsync, de, rgb,
    output graph_on, graph_rgb
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - 640x480@60 raster counters with a one-pixel registered,
// blank-masked RGB/sync/DE output stage for the HDMI/VGA encoder.
module video_timing_gen #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic       SYNC_POL = 1'b0,
  parameter logic [2:0] BG_RGB   = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The counters are 10 bits wide; larger rasters cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
    $error("video_timing_gen: raster totals exceed 10-bit counter range");
  end

  logic [9:0] r_pix_x;
  logic [9:0] r_pix_y;
  logic       r_line_tick;
  logic       r_frame_tick;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_de;
  logic [2:0] r_rgb;

  logic       w_h_end;
  logic       w_v_end;
  logic       w_video_on;
  logic       w_hs_act;
  logic       w_vs_act;
  logic [2:0] w_rgb_next;

  assign w_h_end    = (r_pix_x == H_LAST);
  assign w_v_end    = (r_pix_y == V_LAST);
  assign w_video_on = (r_pix_x < H_VIS) && (r_pix_y < V_VIS);
  assign w_hs_act   = (r_pix_x >= H_SYNC_BEG) && (r_pix_x <= H_SYNC_END);
  assign w_vs_act   = (r_pix_y >= V_SYNC_BEG) && (r_pix_y <= V_SYNC_END);

  // Blanking wins over the graphics layer so nothing leaks into the porches.
  always_comb begin
    w_rgb_next = 3'b000;
    if (w_video_on) begin
      w_rgb_next = vid.graph_on ? vid.graph_rgb : BG_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (pix_en) begin
      if (w_h_end) begin
        r_pix_x <= '0;
        r_pix_y <= w_v_end ? 10'd0 : r_pix_y + 10'd1;
      end else begin
        r_pix_x <= r_pix_x + 10'd1;
      end
    end
  end

  // Ticks are sampled every clk so they stay exactly one clk wide at any pixel rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_line_tick  <= pix_en && w_h_end;
      r_frame_tick <= pix_en && w_h_end && w_v_end;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_rgb   <= 3'b000;
    end else if (pix_en) begin
      r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_de    <= w_video_on;
      r_rgb   <= w_rgb_next;
    end
  end

  assign vid.pix_x      = r_pix_x;
  assign vid.pix_y      = r_pix_y;
  assign vid.video_on   = w_video_on;
  assign vid.line_tick  = r_line_tick;
  assign vid.frame_tick = r_frame_tick;
  assign vid.hsync      = r_hsync;
  assign vid.vsync      = r_vsync;
  assign vid.de         = r_de;
  assign vid.rgb        = r_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench: full-size instance for line-level timing,
// reduced-geometry instance for frame-level wrap, vsync and blanking.
module tb_video_timing_gen;
  logic clk;
  logic reset_a, pix_en_a;
  logic reset_b, pix_en_b;
  int   checks, passed, fails;

  video_timing_gen_if if_a ();
  video_timing_gen_if if_b ();

  video_timing_gen u_dut_a (
    .clk    (clk),
    .reset  (reset_a),
    .pix_en (pix_en_a),
    .vid    (if_a.master)
  );

  // Small raster: H 16/2/4/3 (total 25), V 12/2/2/3 (total 19), 475 pixels per frame.
  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .BG_RGB(3'b101)
  ) u_dut_b (
    .clk    (clk),
    .reset  (reset_b),
    .pix_en (pix_en_b),
    .vid    (if_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; pix_en_a = 1'b1;
    reset_b = 1'b1; pix_en_b = 1'b1;
    step();
    reset_a = 1'b0; reset_b = 1'b0;
    checks++;
    if ({if_a.pix_x, if_a.pix_y} !== 20'd0) begin
      fails++; $display("FAIL reset_xy_a: got x=%0d y=%0d, want 0 0", if_a.pix_x, if_a.pix_y);
    end else passed++;
    checks++;
    if ({if_a.hsync, if_a.vsync, if_a.de, if_a.rgb} !== 6'b110000) begin
      fails++; $display("FAIL reset_out_a: got hs=%b vs=%b de=%b rgb=%b, want 1 1 0 000",
                        if_a.hsync, if_a.vsync, if_a.de, if_a.rgb);
    end else passed++;
    checks++;
    if ({if_a.line_tick, if_a.frame_tick} !== 2'b00) begin
      fails++; $display("FAIL reset_ticks_a: got %b%b, want 00", if_a.line_tick, if_a.frame_tick);
    end else passed++;
    checks++;
    if ({if_b.pix_x, if_b.pix_y, if_b.hsync, if_b.vsync, if_b.de, if_b.rgb} !== {20'd0, 6'b110000}) begin
      fails++; $display("FAIL reset_b: got x=%0d y=%0d hs=%b vs=%b de=%b rgb=%b", if_b.pix_x,
                        if_b.pix_y, if_b.hsync, if_b.vsync, if_b.de, if_b.rgb);
    end else passed++;
  endtask

  task automatic test_line_const();
    int bad_cnt, bad_tick, bad_out, de_n, hs_n, hs_first, hs_last, lt_n, p, px;
    logic exp_de, exp_hs;
    logic [2:0] exp_rgb;
    bad_cnt = 0; bad_tick = 0; bad_out = 0; de_n = 0; hs_n = 0; lt_n = 0;
    hs_first = -1; hs_last = -1;
    if_a.graph_on = 1'b1; if_a.graph_rgb = 3'b110;
    reset_a = 1'b1; pix_en_a = 1'b1; step(); reset_a = 1'b0;
    for (int k = 1; k <= 1700; k++) begin
      step();
      p = k - 1; px = p % 800;
      exp_de  = (px < 640);
      exp_hs  = !(px >= 656 && px <= 751);
      exp_rgb = exp_de ? 3'b110 : 3'b000;
      if (if_a.pix_x !== 10'(k % 800) || if_a.pix_y !== 10'(k / 800) ||
          if_a.video_on !== ((k % 800) < 640)) bad_cnt++;
      if (if_a.line_tick !== (k % 800 == 0) || if_a.frame_tick !== 1'b0) bad_tick++;
      if (if_a.de !== exp_de || if_a.hsync !== exp_hs || if_a.vsync !== 1'b1 ||
          if_a.rgb !== exp_rgb) bad_out++;
      if (if_a.line_tick === 1'b1) lt_n++;
      if (p < 800) begin
        if (if_a.de === 1'b1) de_n++;
        if (if_a.hsync === 1'b0) begin
          hs_n++;
          if (hs_first < 0) hs_first = p;
          hs_last = p;
        end
      end
    end
    checks++;
    if (bad_cnt !== 0) begin fails++; $display("FAIL line_counters: %0d bad pixels, want 0", bad_cnt); end
    else passed++;
    checks++;
    if (bad_tick !== 0) begin fails++; $display("FAIL line_ticks: %0d bad pixels, want 0", bad_tick); end
    else passed++;
    checks++;
    if (bad_out !== 0) begin fails++; $display("FAIL line_outputs: %0d bad pixels, want 0", bad_out); end
    else passed++;
    checks++;
    if (lt_n !== 2) begin fails++; $display("FAIL line_tick_count: got %0d, want 2", lt_n); end
    else passed++;
    checks++;
    if (de_n !== 640) begin fails++; $display("FAIL de_per_line: got %0d, want 640", de_n); end
    else passed++;
    checks++;
    if (hs_n !== 96 || hs_first !== 656 || hs_last !== 751) begin
      fails++; $display("FAIL hsync_window: got n=%0d first=%0d last=%0d, want 96 656 751",
                        hs_n, hs_first, hs_last);
    end else passed++;
  endtask

  task automatic test_latency();
    int bad, p, px;
    logic [2:0] exp_rgb;
    logic [2:0] rgb_639;
    bad = 0; rgb_639 = 3'b000;
    if_a.graph_on = 1'b1;
    reset_a = 1'b1; pix_en_a = 1'b1; step(); reset_a = 1'b0;
    for (int k = 1; k <= 900; k++) begin
      if_a.graph_rgb = if_a.pix_x[2:0];
      step();
      p = k - 1; px = p % 800;
      exp_rgb = (px < 640) ? 3'(p % 8) : 3'b000;
      if (if_a.rgb !== exp_rgb || if_a.de !== (px < 640) ||
          if_a.hsync !== !(px >= 656 && px <= 751)) bad++;
      if (p == 639) rgb_639 = if_a.rgb;
    end
    if_a.graph_rgb = 3'b110;
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL latency_stream: %0d bad pixels, want 0", bad); end
    else passed++;
    checks++;
    if (rgb_639 !== 3'b111) begin
      fails++; $display("FAIL latency_last_active: got %b, want 111", rgb_639);
    end else passed++;
  endtask

  task automatic test_pix_en_pulse();
    int bad_on, bad_hold, lt_clks, p, px;
    logic exp_de, exp_hs;
    logic [2:0] exp_rgb;
    bad_on = 0; bad_hold = 0; lt_clks = 0;
    if_a.graph_on = 1'b1; if_a.graph_rgb = 3'b110;
    reset_a = 1'b1; pix_en_a = 1'b1; step(); reset_a = 1'b0;
    for (int k = 1; k <= 900; k++) begin
      p = k - 1; px = p % 800;
      exp_de  = (px < 640);
      exp_hs  = !(px >= 656 && px <= 751);
      exp_rgb = exp_de ? 3'b110 : 3'b000;
      pix_en_a = 1'b1;
      step();
      if (if_a.pix_x !== 10'(k % 800) || if_a.pix_y !== 10'(k / 800) ||
          if_a.line_tick !== (k % 800 == 0) || if_a.de !== exp_de ||
          if_a.hsync !== exp_hs || if_a.rgb !== exp_rgb) bad_on++;
      if (if_a.line_tick === 1'b1) lt_clks++;
      pix_en_a = 1'b0;
      for (int j = 0; j < 3; j++) begin
        step();
        if (if_a.pix_x !== 10'(k % 800) || if_a.line_tick !== 1'b0 || if_a.de !== exp_de ||
            if_a.hsync !== exp_hs || if_a.rgb !== exp_rgb) bad_hold++;
        if (if_a.line_tick === 1'b1) lt_clks++;
      end
    end
    pix_en_a = 1'b1;
    checks++;
    if (bad_on !== 0) begin fails++; $display("FAIL pulse_enabled: %0d bad pixels, want 0", bad_on); end
    else passed++;
    checks++;
    if (bad_hold !== 0) begin fails++; $display("FAIL pulse_hold: %0d bad clks, want 0", bad_hold); end
    else passed++;
    checks++;
    if (lt_clks !== 1) begin fails++; $display("FAIL pulse_tick_width: got %0d clks, want 1", lt_clks); end
    else passed++;
  endtask

  task automatic test_frame();
    int bad_cnt, bad_out, ft_n, de_n, vs_n, row13, p, px, py;
    logic g, exp_de;
    logic [2:0] exp_rgb;
    bad_cnt = 0; bad_out = 0; ft_n = 0; de_n = 0; vs_n = 0; row13 = 0;
    if_b.graph_rgb = 3'b110;
    reset_b = 1'b1; pix_en_b = 1'b1; step(); reset_b = 1'b0;
    for (int k = 1; k <= 960; k++) begin
      p = k - 1; px = p % 25; py = (p / 25) % 19;
      g = ((p / 475) % 2 == 0);
      if_b.graph_on = g;
      step();
      exp_de  = (px < 16) && (py < 12);
      exp_rgb = !exp_de ? 3'b000 : (g ? 3'b110 : 3'b101);
      if (if_b.pix_x !== 10'(k % 25) || if_b.pix_y !== 10'((k / 25) % 19) ||
          if_b.video_on !== ((k % 25 < 16) && ((k / 25) % 19 < 12)) ||
          if_b.line_tick !== (k % 25 == 0) || if_b.frame_tick !== (k % 475 == 0)) bad_cnt++;
      if (if_b.de !== exp_de || if_b.rgb !== exp_rgb || if_b.hsync !== !(px >= 18 && px <= 21) ||
          if_b.vsync !== !(py >= 14 && py <= 15)) bad_out++;
      if (if_b.frame_tick === 1'b1) ft_n++;
      if (p < 475) begin
        if (if_b.de === 1'b1) de_n++;
        if (if_b.vsync === 1'b0) vs_n++;
        if (py == 13 && if_b.rgb !== 3'b000) row13++;
      end
    end
    checks++;
    if (bad_cnt !== 0) begin fails++; $display("FAIL frame_counters: %0d bad pixels, want 0", bad_cnt); end
    else passed++;
    checks++;
    if (bad_out !== 0) begin fails++; $display("FAIL frame_outputs: %0d bad pixels, want 0", bad_out); end
    else passed++;
    checks++;
    if (ft_n !== 2) begin fails++; $display("FAIL frame_tick_count: got %0d, want 2", ft_n); end
    else passed++;
    checks++;
    if (de_n !== 192) begin fails++; $display("FAIL de_per_frame: got %0d, want 192", de_n); end
    else passed++;
    checks++;
    if (vs_n !== 50) begin fails++; $display("FAIL vsync_pixels: got %0d, want 50", vs_n); end
    else passed++;
    checks++;
    if (row13 !== 0) begin fails++; $display("FAIL blank_row: got %0d lit pixels, want 0", row13); end
    else passed++;
  endtask

  task automatic test_reset_mid();
    if_a.graph_on = 1'b1; if_a.graph_rgb = 3'b110;
    reset_a = 1'b1; pix_en_a = 1'b1; step(); reset_a = 1'b0;
    for (int k = 0; k < 1100; k++) step();
    checks++;
    if (if_a.pix_x !== 10'd300 || if_a.pix_y !== 10'd1 || if_a.rgb !== 3'b110) begin
      fails++; $display("FAIL mid_pre: got x=%0d y=%0d rgb=%b, want 300 1 110",
                        if_a.pix_x, if_a.pix_y, if_a.rgb);
    end else passed++;
    reset_a = 1'b1; step(); reset_a = 1'b0;
    checks++;
    if ({if_a.pix_x, if_a.pix_y, if_a.rgb, if_a.de, if_a.hsync, if_a.vsync} !== {20'd0, 6'b000011}) begin
      fails++; $display("FAIL mid_reset_a: got x=%0d y=%0d rgb=%b de=%b hs=%b vs=%b", if_a.pix_x,
                        if_a.pix_y, if_a.rgb, if_a.de, if_a.hsync, if_a.vsync);
    end else passed++;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (if_a.pix_x !== 10'd5 || if_a.pix_y !== 10'd0 || if_a.rgb !== 3'b110 || if_a.de !== 1'b1) begin
      fails++; $display("FAIL mid_resume: got x=%0d y=%0d rgb=%b de=%b, want 5 0 110 1",
                        if_a.pix_x, if_a.pix_y, if_a.rgb, if_a.de);
    end else passed++;

    reset_b = 1'b1; pix_en_b = 1'b1; step(); reset_b = 1'b0;
    for (int k = 0; k < 355; k++) step();
    checks++;
    if (if_b.vsync !== 1'b0 || if_b.pix_y !== 10'd14) begin
      fails++; $display("FAIL mid_pre_b: got vs=%b y=%0d, want 0 14", if_b.vsync, if_b.pix_y);
    end else passed++;
    pix_en_b = 1'b0; reset_b = 1'b1; step(); reset_b = 1'b0;
    step(); step();
    checks++;
    if ({if_b.pix_x, if_b.pix_y, if_b.rgb, if_b.de, if_b.hsync, if_b.vsync} !== {20'd0, 6'b000011}) begin
      fails++; $display("FAIL reset_no_en_b: got x=%0d y=%0d rgb=%b de=%b hs=%b vs=%b", if_b.pix_x,
                        if_b.pix_y, if_b.rgb, if_b.de, if_b.hsync, if_b.vsync);
    end else passed++;
    pix_en_b = 1'b1; step();
    checks++;
    if (if_b.pix_x !== 10'd1 || if_b.pix_y !== 10'd0) begin
      fails++; $display("FAIL reset_no_en_resume: got x=%0d y=%0d, want 1 0", if_b.pix_x, if_b.pix_y);
    end else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; fails = 0;
    reset_a = 1'b1; pix_en_a = 1'b0; reset_b = 1'b1; pix_en_b = 1'b0;
    if_a.graph_on = 1'b0; if_a.graph_rgb = 3'b000;
    if_b.graph_on = 1'b0; if_b.graph_rgb = 3'b000;
    test_reset();
    test_line_const();
    test_latency();
    test_pix_en_pulse();
    test_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
